hdc_main: RTL and testbench
===========================

# hdc_main

Hyperdimensional-computing (HDC) SMS classifier core. It accepts one packed ASCII message of up to MAX_LENGTH characters and encodes it into a D-bit binary hypervector by trigram binding and majority bundling. It then labels the message ham or spam by Hamming distance to two externally supplied class hypervectors. It sits between the message loader and the result logger; class hypervectors come from an upstream training store.

## Interface
- MAX_LENGTH, 160: maximum characters per message.
- CHAR_W, 7: bits per character (7-bit ASCII).
- D, 512: hypervector dimension.
- BASE_HV, HDC_BASE_HV (package constant): D-bit seed for the item memory.
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin classification; sampled only in IDLE.
- msg_data  in  MAX_LENGTH*CHAR_W  packed message; char i = bits [CHAR_W*i+CHAR_W-1 : CHAR_W*i].
- msg_length  in  8  number of valid characters.
- ham_hv  in  D  ham class hypervector.
- spam_hv  in  D  spam class hypervector.
- busy  out  1  high while a message is being processed.
- label_valid  out  1  one-cycle pulse when the result is ready.
- label  out  1  0 = ham, 1 = spam; held until the next label_valid.
- dist_ham, dist_spam  out  $clog2(D+1) each  Hamming distances; held with label.

## Operation
- Capture on accepted start: msg_data, ham_hv, spam_hv and L = min(msg_length, MAX_LENGTH).
- Item vector: hv(c) = rotate-left(BASE_HV, c) for a 7-bit character c.
- Trigram k, for k = 0..N-1 with N = max(L-2, 0): g_k = rotl(hv(c_k),2) XOR rotl(hv(c_k+1),1) XOR hv(c_k+2).
- Accumulate: D counters, 8 bits each. Counter j increments when g_k[j] = 1. Counters cannot overflow because N ≤ 158.
- Threshold: class bit j = 1 iff 2*cnt_j > N. A tie gives 0. N = 0 gives an all-zero vector.
- Compare: dist_x = popcount(class XOR x_hv). label = 1 iff dist_spam < dist_ham; a tie gives ham (0).
- FSM states and transitions:
  - IDLE goes to ACCUM on start.
  - ACCUM stays for N cycles, one trigram per cycle, then goes to THRESH. If N = 0 it passes through in one cycle.
  - THRESH goes to COMPARE, which goes to DONE, which goes back to IDLE.
- start while busy is ignored. The inputs after capture are don't-care.

## Timing
- Reset values: all outputs 0, counters 0, FSM in IDLE.
- start is sampled at edge 0.
- busy is high from after edge 0 until label_valid falls.
- label_valid is high for exactly one cycle, after edge N+3.
- Latency: N+3 cycles from the start edge to label_valid.
- label, dist_ham and dist_spam update on the same edge that raises label_valid.
- Reset mid-operation:
  - immediately returns to IDLE and clears the counters and all outputs;
  - no label_valid is produced for the aborted message.
- start in the DONE cycle is ignored; start is accepted again on the next IDLE cycle.

## Configuration
- HDC_TAG_CHECK_EN defined:
  - adds input expected_tag (1 bit), captured with start;
  - adds output tag_mismatch (1 bit), = label XOR expected_tag, valid with label_valid, reset 0.
- HDC_TAG_CHECK_EN undefined: neither port exists and the behaviour is otherwise identical.

## Structure
- Package hdc_pkg holds:
  - MAX_LENGTH, CHAR_W, D;
  - the FSM state enum;
  - HDC_BASE_HV: D/32 words, word k (k = 0 at LSB) is the (k+1)-th xorshift32 output (x ^= x<<13; x ^= x>>17; x ^= x<<5) from seed 1.
  - function rotl;
  - function popcount.
- One sub-module, hdc_trigram_encoder: combinational, three characters in, g_k out.

## Test plan
- Reset asserted with random inputs: every output reads 0; after release, busy stays 0 without start.
- Length 2, ham_hv = 0, spam_hv = all ones:
  - label_valid 3 cycles after start;
  - dist_ham = 0, dist_spam = 512, label = 0.
- Length 3 "abc", spam_hv = g_0, ham_hv = ~g_0:
  - label_valid after 4 cycles;
  - label = 1, dist_spam = 0, dist_ham = 512.
- ham_hv == spam_hv, any message: equal distances, label = 0 (tie goes to ham).
- msg_length = 200: clamped to 160, N = 158, label_valid 161 cycles after start. A second start pulsed mid-run is ignored.
- Reset pulsed during ACCUM:
  - busy drops immediately; no label_valid;
  - a following length-3 run matches the standalone result.
- Tag check, with HDC_TAG_CHECK_EN defined: repeat the "abc" case with expected_tag = 0; tag_mismatch = 1 with label_valid.

Source files
------------

// File: rtl/hdc_pkg.sv
// Shared definitions for the HDC SMS classifier: dimensions, FSM state
// encoding, the item-memory seed vector and the rotate/popcount helpers.
package hdc_pkg;

  localparam int MAX_LENGTH = 160;
  localparam int CHAR_W     = 7;
  localparam int D          = 512;
  localparam int MSG_W      = MAX_LENGTH * CHAR_W;
  localparam int DIST_W     = $clog2(D + 1);
  localparam int ROT_W      = $clog2(D);
  localparam int CNT_W      = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ACCUM   = 3'd1,
    ST_THRESH  = 3'd2,
    ST_COMPARE = 3'd3,
    ST_DONE    = 3'd4
  } hdc_state_e;

  // Seed vector: 32-bit word k holds the (k+1)-th xorshift32 output from seed 1.
  function automatic logic [D-1:0] gen_base_hv();
    logic [31:0]  x;
    logic [D-1:0] v;
    x = 32'd1;
    v = '0;
    for (int k = 0; k < D / 32; k++) begin
      x = x ^ (x << 13);
      x = x ^ (x >> 17);
      x = x ^ (x << 5);
      v[32*k +: 32] = x;
    end
    return v;
  endfunction

  localparam logic [D-1:0] HDC_BASE_HV = gen_base_hv();

  // Rotate a hypervector left by s positions (s < D).
  function automatic logic [D-1:0] rotl(input logic [D-1:0] v, input logic [ROT_W-1:0] s);
    return (v << s) | (v >> (D - int'(s)));
  endfunction

  // Number of set bits in a hypervector.
  function automatic logic [DIST_W-1:0] popcount(input logic [D-1:0] v);
    logic [DIST_W-1:0] n;
    n = '0;
    for (int i = 0; i < D; i++) begin
      n = n + {{(DIST_W-1){1'b0}}, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/hdc_trigram_encoder.sv
// Combinational trigram binder: g = rotl(hv(c0),2) ^ rotl(hv(c1),1) ^ hv(c2),
// where hv(c) is the seed vector rotated left by the character code.
module hdc_trigram_encoder
  import hdc_pkg::*;
(
  input  logic [CHAR_W-1:0] c0,
  input  logic [CHAR_W-1:0] c1,
  input  logic [CHAR_W-1:0] c2,
  output logic [D-1:0]      g
);

  logic [D-1:0] hv0;
  logic [D-1:0] hv1;
  logic [D-1:0] hv2;

  // Item memory lookup is a pure rotation of the seed, so no storage is needed.
  assign hv0 = rotl(HDC_BASE_HV, ROT_W'(c0));
  assign hv1 = rotl(HDC_BASE_HV, ROT_W'(c1));
  assign hv2 = rotl(HDC_BASE_HV, ROT_W'(c2));

  // Position binding: older characters are rotated further.
  assign g = rotl(hv0, ROT_W'(2)) ^ rotl(hv1, ROT_W'(1)) ^ hv2;

endmodule

// File: rtl/hdc_main.sv
// HDC SMS classifier top. Encodes a captured message into a bundled
// hypervector (one trigram per ACCUM cycle), thresholds it by majority and
// labels it ham/spam by Hamming distance to the two class vectors.
// Optional feature macro: HDC_TAG_CHECK_EN adds expected_tag / tag_mismatch.
//
// Handshake: start is a level sampled only in IDLE; an accepted start
// captures every input and raises busy. label_valid is a one-cycle pulse
// (no back-pressure); label and distances hold until the next pulse. busy
// falls on the same edge that drops label_valid.
module hdc_main
  import hdc_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [MSG_W-1:0]  msg_data,
  input  logic [7:0]        msg_length,
  input  logic [D-1:0]      ham_hv,
  input  logic [D-1:0]      spam_hv,
`ifdef HDC_TAG_CHECK_EN
  input  logic              expected_tag,
  output logic              tag_mismatch,
`endif
  output logic              busy,
  output logic              label_valid,
  output logic              label,
  output logic [DIST_W-1:0] dist_ham,
  output logic [DIST_W-1:0] dist_spam,
  output hdc_state_e        state
);

  logic [MSG_W-1:0]  msg_q;
  logic [D-1:0]      ham_q;
  logic [D-1:0]      spam_q;
  logic [7:0]        n_q;
  logic [7:0]        k_q;
  logic [D-1:0]      class_q;
  logic [CNT_W-1:0]  cnt [D];
`ifdef HDC_TAG_CHECK_EN
  logic              tag_q;
`endif

  logic [7:0]        len_clamp;
  logic [7:0]        n_calc;
  logic [D-1:0]      g;
  logic              accum_en;
  logic              capture;
  logic [D-1:0]      class_next;
  logic [DIST_W-1:0] dist_ham_next;
  logic [DIST_W-1:0] dist_spam_next;
  logic              label_next;

  // Trigram count N = max(min(len, MAX_LENGTH) - 2, 0).
  assign len_clamp = (msg_length > 8'(MAX_LENGTH)) ? 8'(MAX_LENGTH) : msg_length;
  assign n_calc    = (len_clamp > 8'd2) ? (len_clamp - 8'd2) : 8'd0;

  assign capture  = (state == ST_IDLE) && start;
  assign accum_en = (state == ST_ACCUM) && (k_q != n_q);

  // The message register shifts right one character per trigram, so the
  // current trigram is always the lowest three characters.
  hdc_trigram_encoder u_enc (
    .c0 (msg_q[0*CHAR_W +: CHAR_W]),
    .c1 (msg_q[1*CHAR_W +: CHAR_W]),
    .c2 (msg_q[2*CHAR_W +: CHAR_W]),
    .g  (g)
  );

  // Majority threshold: bit set only on a strict majority (ties give 0).
  always_comb begin
    class_next = '0;
    for (int j = 0; j < D; j++) begin
      class_next[j] = ({cnt[j], 1'b0} > {1'b0, n_q});
    end
  end

  assign dist_ham_next  = popcount(class_q ^ ham_q);
  assign dist_spam_next = popcount(class_q ^ spam_q);
  assign label_next     = (dist_spam_next < dist_ham_next);

  // Bundling counters: cleared on capture, one increment per set trigram bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < D; j++) cnt[j] <= '0;
    end else if (capture) begin
      for (int j = 0; j < D; j++) cnt[j] <= '0;
    end else if (accum_en) begin
      for (int j = 0; j < D; j++) cnt[j] <= cnt[j] + CNT_W'(g[j]);
    end
  end

  // Control FSM with registered outputs and captured operands.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      label_valid <= 1'b0;
      label       <= 1'b0;
      dist_ham    <= '0;
      dist_spam   <= '0;
      msg_q       <= '0;
      ham_q       <= '0;
      spam_q      <= '0;
      n_q         <= '0;
      k_q         <= '0;
      class_q     <= '0;
`ifdef HDC_TAG_CHECK_EN
      tag_q        <= 1'b0;
      tag_mismatch <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            msg_q  <= msg_data;
            ham_q  <= ham_hv;
            spam_q <= spam_hv;
            n_q    <= n_calc;
            k_q    <= '0;
            busy   <= 1'b1;
`ifdef HDC_TAG_CHECK_EN
            tag_q  <= expected_tag;
`endif
            state  <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          // N trigram cycles, then one cycle to leave (N = 0 passes straight through).
          if (k_q == n_q) begin
            state <= ST_THRESH;
          end else begin
            msg_q <= msg_q >> CHAR_W;
            k_q   <= k_q + 8'd1;
          end
        end
        ST_THRESH: begin
          class_q <= class_next;
          state   <= ST_COMPARE;
        end
        ST_COMPARE: begin
          dist_ham    <= dist_ham_next;
          dist_spam   <= dist_spam_next;
          label       <= label_next;
          label_valid <= 1'b1;
`ifdef HDC_TAG_CHECK_EN
          tag_mismatch <= label_next ^ tag_q;
`endif
          state       <= ST_DONE;
        end
        ST_DONE: begin
          label_valid <= 1'b0;
          busy        <= 1'b0;
          state       <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hdc_main.sv
// Self-checking bench for hdc_main: driver tasks push expected results from a
// behavioural HDC model; a monitor pops and compares on every label_valid.
`timescale 1ns/1ps
module tb_hdc_main;
  import hdc_pkg::*;

  localparam int DW = $clog2(D + 1);

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [MSG_W-1:0] msg_data = '0;
  logic [7:0]       msg_length = '0;
  logic [D-1:0]     ham_hv = '0;
  logic [D-1:0]     spam_hv = '0;
  logic             busy;
  logic             label_valid;
  logic             label;
  logic [DW-1:0]    dist_ham;
  logic [DW-1:0]    dist_spam;
  hdc_state_e       state;
`ifdef HDC_TAG_CHECK_EN
  logic             expected_tag = 1'b0;
  logic             tag_mismatch;
  bit               tag_sel = 1'b0;
  logic [0:0]       exp_tag_q[$];
`endif

  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  logic        prev_lv = 1'b0;

  logic [0:0]    exp_label_q[$];
  logic [DW-1:0] exp_dham_q[$];
  logic [DW-1:0] exp_dspam_q[$];
  logic [31:0]   exp_lat_q[$];
  logic [31:0]   stamp_q[$];

  logic [D-1:0]  base_hv;

  hdc_main dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .msg_data    (msg_data),
    .msg_length  (msg_length),
    .ham_hv      (ham_hv),
    .spam_hv     (spam_hv),
`ifdef HDC_TAG_CHECK_EN
    .expected_tag(expected_tag),
    .tag_mismatch(tag_mismatch),
`endif
    .busy        (busy),
    .label_valid (label_valid),
    .label       (label),
    .dist_ham    (dist_ham),
    .dist_spam   (dist_spam),
    .state       (state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  function automatic logic [D-1:0] m_base();
    bit [31:0]    x;
    logic [D-1:0] v;
    x = 32'd1;
    v = '0;
    for (int k = 0; k < D / 32; k++) begin
      x = x ^ (x << 13);
      x = x ^ (x >> 17);
      x = x ^ (x << 5);
      v[32*k +: 32] = x;
    end
    return v;
  endfunction

  // Bit j moves to position (j+s) mod D.
  function automatic logic [D-1:0] m_rotl(input logic [D-1:0] v, input int s);
    logic [D-1:0] r;
    for (int j = 0; j < D; j++) r[(j + s) % D] = v[j];
    return r;
  endfunction

  function automatic logic [D-1:0] m_trigram(input int a, input int b, input int c);
    return m_rotl(m_rotl(base_hv, a), 2) ^ m_rotl(m_rotl(base_hv, b), 1) ^ m_rotl(base_hv, c);
  endfunction

  function automatic int m_pop(input logic [D-1:0] v);
    int n;
    n = 0;
    for (int j = 0; j < D; j++) if (v[j]) n++;
    return n;
  endfunction

  // Reference encoder: counts per dimension, strict majority over N trigrams.
  task automatic model_class(input logic [MSG_W-1:0] msg, input int len,
                             output logic [D-1:0] cls, output int n);
    int           l;
    int           cnt [D];
    logic [D-1:0] gk;
    l = (len > MAX_LENGTH) ? MAX_LENGTH : len;
    n = (l > 2) ? l - 2 : 0;
    for (int j = 0; j < D; j++) cnt[j] = 0;
    for (int k = 0; k < n; k++) begin
      gk = m_trigram(int'(msg[CHAR_W*k +: CHAR_W]), int'(msg[CHAR_W*(k+1) +: CHAR_W]),
                     int'(msg[CHAR_W*(k+2) +: CHAR_W]));
      for (int j = 0; j < D; j++) cnt[j] += int'(gk[j]);
    end
    for (int j = 0; j < D; j++) cls[j] = (2 * cnt[j] > n);
  endtask

  function automatic logic [MSG_W-1:0] pack_str(input string s);
    logic [MSG_W-1:0] m;
    byte              b;
    m = '0;
    for (int i = 0; i < s.len(); i++) begin
      b = s[i];
      m[CHAR_W*i +: CHAR_W] = b[6:0];
    end
    return m;
  endfunction

  function automatic logic [MSG_W-1:0] rand_msg();
    logic [MSG_W-1:0] m;
    for (int i = 0; i < MAX_LENGTH; i++) m[CHAR_W*i +: CHAR_W] = 7'($urandom_range(32, 126));
    return m;
  endfunction

  function automatic logic [D-1:0] rand_hv();
    logic [D-1:0] v;
    for (int k = 0; k < D / 32; k++) v[32*k +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [D-1:0] sparse_noise(input int bits);
    logic [D-1:0] v;
    v = '0;
    for (int i = 0; i < bits; i++) v[$urandom_range(0, D-1)] = 1'b1;
    return v;
  endfunction

  task automatic wait_idle(input string name);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check({name, "_busy_timeout"}, 32'(busy), 32'd0);
  endtask

  // ---------------- driver ----------------
  task automatic run_msg(input string name, input logic [MSG_W-1:0] msg, input logic [7:0] len,
                         input logic [D-1:0] ham, input logic [D-1:0] spam, input bit pulse_mid);
    logic [D-1:0] cls;
    int           n;
    int           dh;
    int           ds;
    bit           lab;
    model_class(msg, int'(len), cls, n);
    dh  = m_pop(cls ^ ham);
    ds  = m_pop(cls ^ spam);
    lab = (ds < dh);
    @(negedge clk);
    exp_label_q.push_back(lab);
    exp_dham_q.push_back(DW'(dh));
    exp_dspam_q.push_back(DW'(ds));
    exp_lat_q.push_back(32'(n + 3));
    stamp_q.push_back(cyc);
`ifdef HDC_TAG_CHECK_EN
    expected_tag = tag_sel;
    exp_tag_q.push_back(lab ^ tag_sel);
`endif
    start      = 1'b1;
    msg_data   = msg;
    msg_length = len;
    ham_hv     = ham;
    spam_hv    = spam;
    @(negedge clk);
    start      = 1'b0;
    msg_data   = rand_msg();
    msg_length = 8'($urandom_range(0, 255));
    ham_hv     = rand_hv();
    spam_hv    = rand_hv();
    if (pulse_mid) begin
      repeat (10) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_idle(name);
    check({name, "_label_held"}, 32'(label), 32'(lab));
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (label_valid) begin
      if (exp_label_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_label_valid: got 1 required 0 at cycle %0d", cyc);
      end else begin
        logic [31:0] stamp;
        stamp = stamp_q.pop_front();
        check("label", 32'(label), 32'(exp_label_q.pop_front()));
        check("dist_ham", 32'(dist_ham), 32'(exp_dham_q.pop_front()));
        check("dist_spam", 32'(dist_spam), 32'(exp_dspam_q.pop_front()));
        check("latency", cyc - stamp - 32'd1, exp_lat_q.pop_front());
`ifdef HDC_TAG_CHECK_EN
        check("tag_mismatch", 32'(tag_mismatch), 32'(exp_tag_q.pop_front()));
`endif
      end
      check("busy_with_valid", 32'(busy), 32'd1);
      check("valid_one_cycle", 32'(prev_lv), 32'd0);
    end
    prev_lv = label_valid;
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [MSG_W-1:0] m;
    logic [D-1:0]     g0;
    logic [D-1:0]     h;
    logic [D-1:0]     cls;
    int               n;
    int               len;
    base_hv = m_base();

    // Reset with random inputs toggling.
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      start      = 1'b1;
      msg_data   = rand_msg();
      msg_length = 8'($urandom_range(0, 255));
      ham_hv     = rand_hv();
      spam_hv    = rand_hv();
    end
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_label_valid", 32'(label_valid), 32'd0);
    check("rst_label", 32'(label), 32'd0);
    check("rst_dist_ham", 32'(dist_ham), 32'd0);
    check("rst_dist_spam", 32'(dist_spam), 32'd0);
    check("rst_state", 32'(state), 32'(ST_IDLE));
`ifdef HDC_TAG_CHECK_EN
    check("rst_tag_mismatch", 32'(tag_mismatch), 32'd0);
`endif
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    // Length 2: N = 0, class vector all zero.
    run_msg("len2", pack_str("hi"), 8'd2, '0, '1, 1'b0);

    // "abc": spam equals the single trigram.
    g0 = m_trigram(int'("a"), int'("b"), int'("c"));
`ifdef HDC_TAG_CHECK_EN
    tag_sel = 1'b0;
`endif
    run_msg("abc", pack_str("abc"), 8'd3, ~g0, g0, 1'b0);

    // Equal class vectors: tie goes to ham.
    h = rand_hv();
    run_msg("tie", rand_msg(), 8'($urandom_range(3, 40)), h, h, 1'b0);

    // Over-length message clamps to MAX_LENGTH; mid-run start ignored.
    run_msg("len200", rand_msg(), 8'd200, rand_hv(), rand_hv(), 1'b1);

    // Reset during ACCUM aborts without a result.
    @(negedge clk);
    start      = 1'b1;
    msg_data   = rand_msg();
    msg_length = 8'd100;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_state", 32'(state), 32'(ST_IDLE));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    run_msg("abc_after_abort", pack_str("abc"), 8'd3, ~g0, g0, 1'b0);

    // Random messages; some class vectors near the encoded vector to hit both labels.
    for (int t = 0; t < 8; t++) begin
      m   = rand_msg();
      len = $urandom_range(0, 165);
`ifdef HDC_TAG_CHECK_EN
      tag_sel = 1'($urandom_range(0, 1));
`endif
      model_class(m, len, cls, n);
      case (t % 3)
        0:       run_msg("rand", m, 8'(len), rand_hv(), rand_hv(), 1'b0);
        1:       run_msg("rand_spamish", m, 8'(len), rand_hv(), cls ^ sparse_noise(20), 1'b0);
        default: run_msg("rand_hamish", m, 8'(len), cls ^ sparse_noise(20), rand_hv(), 1'b0);
      endcase
    end

    repeat (5) @(negedge clk);
    check("pending_results", 32'(exp_label_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
